// File: rtl/ioctl_ldr_bridge.sv
// Byte-to-word bridge between the HPS ioctl download stream and a 16-bit loader write port.
// Bytes are paired into big-endian words, queued in a small FIFO and written with a req/ack handshake.
module ioctl_ldr_bridge #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 20
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          ldr_aen,
  output logic [AW-1:0] ldr_addr,
  output logic [15:0]   ldr_wdat,
  output logic [1:0]    ldr_be,
  output logic          ldr_wr,
  input  logic          ldr_ack,
  output logic          ldr_done,
  output logic          ldr_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;
  localparam int unsigned EW = AW + 18;

  typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

  state_e state_q, state_d;

  logic          dl_q, ack_q, seen_q, ovf_q;
  logic          pend_v_q, pend_v_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_dat_q, pend_dat_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ldr_addr_q;
  logic [15:0]   ldr_wdat_q;
  logic [1:0]    ldr_be_q;

  logic          unused_addr;
  logic [AW-1:0] baddr;
  logic          byte_acc, contig, push_a, push_b, acc_a, acc_b, pop, load;
  logic          ack_rise, dl_rise, empty, ovf_set;
  logic [EW-1:0] ent_a, ent_b;
  logic [CW-1:0] room, n_push;

  assign unused_addr = ^ioctl_addr[24:AW];
  assign baddr       = ioctl_addr[AW-1:0];
  assign byte_acc    = ioctl_wr & ioctl_download;
  assign ack_rise    = ldr_ack & ~ack_q;
  assign dl_rise     = ioctl_download & ~dl_q;
  assign empty       = (cnt_q == '0);
  assign pop         = (state_q == StReq) & ack_rise;

  // Pending bytes are always even, so contiguity is an odd byte in the same word.
  assign contig = pend_v_q & baddr[0] & (baddr[AW-1:1] == pend_addr_q[AW-1:1]);
  assign push_a = pend_v_q & ((byte_acc & ~contig) | ~ioctl_download);
  assign ent_a  = {pend_addr_q, pend_dat_q, 8'h00, 2'b10};
  assign push_b = byte_acc & baddr[0];
  assign ent_b  = {baddr[AW-1:1], 1'b0, (contig ? pend_dat_q : 8'h00), ioctl_dout,
                   (contig ? 2'b11 : 2'b01)};

  // Up to two pushes per cycle; a slot freed by a same-cycle pop is usable.
  assign room    = CW'(DEPTH) + CW'(pop) - CW'(cnt_q);
  assign acc_a   = push_a & (room != '0);
  assign acc_b   = push_b & (room > CW'(acc_a));
  assign n_push  = CW'(acc_a) + CW'(acc_b);
  assign ovf_set = (push_a & ~acc_a) | (push_b & ~acc_b);

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;
    if (byte_acc) begin
      pend_v_d = ~baddr[0];
      if (!baddr[0]) begin
        pend_addr_d = baddr;
        pend_dat_d  = ioctl_dout;
      end
    end else if (!ioctl_download) begin
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (acc_a) mem_q[wr_ptr_q] <= ent_a;
    if (acc_b) mem_q[wr_ptr_q + PW'(acc_a)] <= ent_b;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      ack_q       <= 1'b0;
      seen_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ldr_addr_q  <= '0;
      ldr_wdat_q  <= '0;
      ldr_be_q    <= '0;
    end else begin
      dl_q        <= ioctl_download;
      ack_q       <= ldr_ack;
      seen_q      <= seen_q | ioctl_download;
      ovf_q       <= (ovf_q & ~((state_q == StDone) & dl_rise)) | ovf_set;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_dat_q  <= pend_dat_d;
      wr_ptr_q    <= wr_ptr_q + PW'(n_push);
      rd_ptr_q    <= rd_ptr_q + PW'(pop);
      cnt_q       <= (PW+1)'(CW'(cnt_q) + n_push - CW'(pop));
      if (load) {ldr_addr_q, ldr_wdat_q, ldr_be_q} <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StReq;
          load    = 1'b1;
        end else if (!ioctl_download && seen_q && !pend_v_q) begin
          state_d = StDone;
        end
      end
      StReq:   if (ack_rise) state_d = StGap;
      StGap:   state_d = StIdle;
      StDone:  if (dl_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ldr_wr     = (state_q == StReq);
    ldr_done   = (state_q == StDone);
    ldr_ovf    = ovf_q;
    ldr_addr   = ldr_addr_q;
    ldr_wdat   = ldr_wdat_q;
    ldr_be     = ldr_be_q;
    ioctl_wait = (cnt_q >= (PW+1)'(DEPTH - 2));
    // Gated by reset so the bus is released while reset_n is low.
    ldr_aen    = reset_n & ~ldr_done &
                 (ioctl_download | ~empty | pend_v_q | (state_q == StReq) | (state_q == StGap));
  end

endmodule
